// File: rtl/hdc_seq_ctrl.sv
// hdc_seq_ctrl: owns the gen_class HDC classifier. Trains it on the first
// NUM_TRAIN accepted samples of a run, then streams inference launches and
// returns one predicted label per accepted sample, with a seizure alarm
// after ALARM_COUNT consecutive seizure predictions.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; alarm from the previous run is held
// TRAIN  | accepting labelled samples, launching gen_class training
// SWITCH | one-cycle bubble so the last training update settles
// INFER  | accepting samples, launching gen_class inference
// DRAIN  | no new samples; waiting for in-flight predictions to return
module hdc_seq_ctrl #(
  parameter int DIMENSIONS   = 5,
  parameter int NUM_TRAIN    = 3,
  parameter int PRED_LATENCY = 1,
  parameter int ALARM_COUNT  = 2
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DIMENSIONS-1:0]          in_hv,
  input  logic                           in_label,
  output logic                           gc_op,
  output logic                           gc_trained_label,
  output logic [DIMENSIONS-1:0]          gc_in_hv,
  input  logic                           gc_predicted_label,
  output logic                           out_valid,
  output logic                           out_label,
  output logic                           alarm,
  output logic [$clog2(NUM_TRAIN+1)-1:0] train_count,
  output logic                           busy,
  output logic                           done
);

  localparam int TC_W  = $clog2(NUM_TRAIN + 1);
  localparam int RUN_W = $clog2(ALARM_COUNT + 1);

  localparam logic [TC_W-1:0]  TRAIN_LAST = TC_W'(NUM_TRAIN - 1);
  localparam logic [RUN_W-1:0] ALARM_MAX  = RUN_W'(ALARM_COUNT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TRAIN  = 3'd1;
  localparam logic [2:0] S_SWITCH = 3'd2;
  localparam logic [2:0] S_INFER  = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]              state;
  logic [2:0]              state_nxt;
  logic                    accept;
  logic                    launch_inf;
  logic                    start_run;
  logic [PRED_LATENCY-1:0] vld_pipe;
  logic                    pending;
  logic                    pred_fire;
  logic [RUN_W-1:0]        run_cnt;
  logic [RUN_W-1:0]        run_nxt;

  assign in_ready   = (state == S_TRAIN) || (state == S_INFER);
  assign busy       = (state != S_IDLE);
  assign accept     = in_valid && in_ready;
  assign launch_inf = accept && (state == S_INFER);
  assign start_run  = (state == S_IDLE) && start;
  // Only inference launches occupy the prediction pipeline, so DRAIN
  // never waits on training traffic.
  assign pending    = |vld_pipe;
  assign pred_fire  = vld_pipe[PRED_LATENCY-1];

  // Next-state decode; stop wins over the TRAIN->SWITCH transition.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_TRAIN;
      S_TRAIN: begin
        if (stop)                                   state_nxt = S_DRAIN;
        else if (accept && train_count == TRAIN_LAST) state_nxt = S_SWITCH;
      end
      S_SWITCH: state_nxt = stop ? S_DRAIN : S_INFER;
      S_INFER:  if (stop) state_nxt = S_DRAIN;
      S_DRAIN:  if (!pending) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State register and one-cycle done pulse on the DRAIN exit edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == S_DRAIN) && !pending;
    end
  end

  // Training sample counter, cleared at the start of each run.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      train_count <= '0;
    end else if (start_run) begin
      train_count <= '0;
    end else if (accept && (state == S_TRAIN)) begin
      train_count <= train_count + TC_W'(1);
    end
  end

  // Launch registers; idle cycles park gen_class in inference with a zero
  // vector so its class memories only move on training launches.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gc_op            <= 1'b1;
      gc_in_hv         <= '0;
      gc_trained_label <= 1'b0;
    end else if (accept) begin
      gc_op            <= (state == S_INFER);
      gc_in_hv         <= in_hv;
      gc_trained_label <= (state == S_TRAIN) ? in_label : 1'b0;
    end else begin
      gc_op            <= 1'b1;
      gc_in_hv         <= '0;
      gc_trained_label <= 1'b0;
    end
  end

  // Valid shift register tracking inference launches until their label returns.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= launch_inf;
      for (int i = 1; i < PRED_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  // Saturating run length of consecutive seizure predictions.
  always_comb begin
    run_nxt = '0;
    if (gc_predicted_label) begin
      run_nxt = (run_cnt == ALARM_MAX) ? run_cnt : run_cnt + RUN_W'(1);
    end
  end

  // Prediction strobe, label capture and alarm; alarm persists until the next start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid <= 1'b0;
      out_label <= 1'b0;
      run_cnt   <= '0;
      alarm     <= 1'b0;
    end else begin
      out_valid <= pred_fire;
      out_label <= pred_fire & gc_predicted_label;
      if (pred_fire) begin
        run_cnt <= run_nxt;
        alarm   <= (run_nxt == ALARM_MAX);
      end else if (start_run) begin
        run_cnt <= '0;
        alarm   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdc_seq_ctrl.sv
// Testbench for hdc_seq_ctrl: directed test-plan scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_hdc_seq_ctrl;

  localparam int DIM = 5;
  localparam int NT  = 3;
  localparam int PL  = 1;
  localparam int AC  = 2;
  localparam int TCW = $clog2(NT + 1);

  logic           clk = 1'b1;
  logic           nrst = 1'b0;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic           in_valid = 1'b0;
  logic [DIM-1:0] in_hv = '0;
  logic           in_label = 1'b0;
  logic           gc_predicted_label = 1'b0;
  logic           in_ready;
  logic           gc_op;
  logic           gc_trained_label;
  logic [DIM-1:0] gc_in_hv;
  logic           out_valid;
  logic           out_label;
  logic           alarm;
  logic [TCW-1:0] train_count;
  logic           busy;
  logic           done;

  hdc_seq_ctrl #(
    .DIMENSIONS(DIM), .NUM_TRAIN(NT), .PRED_LATENCY(PL), .ALARM_COUNT(AC)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_hv(in_hv), .in_label(in_label),
    .gc_op(gc_op), .gc_trained_label(gc_trained_label), .gc_in_hv(gc_in_hv),
    .gc_predicted_label(gc_predicted_label),
    .out_valid(out_valid), .out_label(out_label), .alarm(alarm),
    .train_count(train_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: run phase plus a queue of due edges for predictions.
  typedef enum int {M_IDLE, M_TRAIN, M_SWITCH, M_INFER, M_DRAIN} mode_t;
  mode_t          m_mode;
  int             m_tc, m_run, edge_n;
  int             due_q[$];
  logic           e_op, e_tl, e_ov, e_ol, e_alarm, e_done;
  logic [DIM-1:0] e_hv;
  bit             last_acc;

  task automatic model_reset();
    m_mode = M_IDLE; m_tc = 0; m_run = 0; due_q.delete();
    e_op = 1'b1; e_hv = '0; e_tl = 1'b0; e_ov = 1'b0; e_ol = 1'b0;
    e_alarm = 1'b0; e_done = 1'b0;
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, (m_mode == M_TRAIN || m_mode == M_INFER));
    chk("busy", busy, (m_mode != M_IDLE));
    chk("done", done, e_done);
    chk("gc_op", gc_op, e_op);
    chk("gc_in_hv", gc_in_hv, e_hv);
    chk("gc_trained_label", gc_trained_label, e_tl);
    chk("out_valid", out_valid, e_ov);
    if (e_ov) chk("out_label", out_label, e_ol);
    chk("alarm", alarm, e_alarm);
    chk("train_count", train_count, m_tc);
  endtask

  // One clock: drive at negedge, advance model for the edge, check after it.
  // pr < 0 drives a random predicted label, otherwise pr itself.
  task automatic cyc(input bit s, input bit sp, input bit v,
                     input logic [DIM-1:0] hv, input bit l, input int pr);
    bit   acc, had;
    logic p;
    @(negedge clk);
    p = (pr < 0) ? 1'($urandom_range(0, 1)) : 1'(pr);
    start = s; stop = sp; in_valid = v; in_hv = hv; in_label = l;
    gc_predicted_label = p;
    edge_n++;
    acc = v && (m_mode == M_TRAIN || m_mode == M_INFER);
    if (acc) begin
      e_op = (m_mode == M_INFER); e_hv = hv; e_tl = (m_mode == M_TRAIN) ? l : 1'b0;
    end else begin
      e_op = 1'b1; e_hv = '0; e_tl = 1'b0;
    end
    had = (due_q.size() != 0);
    e_ov = 1'b0; e_done = 1'b0;
    if (had && due_q[0] == edge_n) begin
      void'(due_q.pop_front());
      e_ov = 1'b1; e_ol = p;
      m_run = p ? ((m_run < AC) ? m_run + 1 : AC) : 0;
      e_alarm = (m_run == AC);
    end
    if (acc && m_mode == M_INFER) due_q.push_back(edge_n + PL);
    case (m_mode)
      M_IDLE:   if (s) begin m_mode = M_TRAIN; m_tc = 0; m_run = 0; e_alarm = 1'b0; end
      M_TRAIN: begin
        if (acc) m_tc++;
        if (sp) m_mode = M_DRAIN;
        else if (acc && m_tc == NT) m_mode = M_SWITCH;
      end
      M_SWITCH: m_mode = sp ? M_DRAIN : M_INFER;
      M_INFER:  if (sp) m_mode = M_DRAIN;
      M_DRAIN:  if (!had) begin m_mode = M_IDLE; e_done = 1'b1; end
      default:  m_mode = M_IDLE;
    endcase
    @(posedge clk);
    #1;
    check_all();
    last_acc = acc;
  endtask

  task automatic send(input logic [DIM-1:0] hv, input bit l);
    int n;
    n = 0;
    do begin
      cyc(1'b0, 1'b0, 1'b1, hv, l, -1);
      n++;
    end while (!last_acc && n < 8);
    chk("send_accepted", last_acc, 1'b1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_gc_op"}, gc_op, 1'b1);
    chk({tag, "_gc_in_hv"}, gc_in_hv, '0);
    chk({tag, "_gc_tl"}, gc_trained_label, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_alarm"}, alarm, 1'b0);
    chk({tag, "_train_count"}, train_count, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_ov, saw_done;
    logic [DIM-1:0] stream [5];
    model_reset();
    edge_n = 0;
    in_valid = 1'b1; in_hv = 5'b11111;
    #20;
    chk_reset_values("reset");
    #5 nrst = 1'b1;

    // IDLE never accepts
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 5'b10101, 1'b1, -1);

    // Training run
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, -1);
    send(5'b11111, 1'b1);
    send(5'b10001, 1'b0);
    send(5'b11111, 1'b1);
    chk("train_count_final", train_count, NT);
    chk("switch_bubble_ready", in_ready, 1'b0);

    // Inference stream
    stream = '{5'b11111, 5'b11101, 5'b00111, 5'b00000, 5'b00001};
    foreach (stream[i]) send(stream[i], 1'b0);

    // Alarm: predictions 1, 1, 0
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b1, 5'b01010, 1'b0, 0);
    cyc(1'b0, 1'b0, 1'b1, 5'b01011, 1'b0, 1);
    chk("alarm_first_pred", alarm, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 5'b01100, 1'b0, 1);
    chk("alarm_rise", alarm, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 0);
    chk("alarm_fall", alarm, 1'b0);

    // Stop on the same edge as an inference accept
    cyc(1'b0, 1'b1, 1'b1, 5'b11011, 1'b0, -1);
    chk("stop_launch_op", gc_op, 1'b1);
    chk("stop_launch_hv", gc_in_hv, 5'b11011);
    saw_ov = 1'b0; saw_done = 1'b0;
    for (int k = 0; k < 10 && !saw_done; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 5'b00110, 1'b0, -1);
      if (out_valid && busy) saw_ov = 1'b1;
      if (done) saw_done = 1'b1;
      chk("drain_ready", in_ready, 1'b0);
    end
    chk("drain_out_valid", saw_ov, 1'b1);
    chk("drain_done", saw_done, 1'b1);

    // Second run with a three-cycle gap mid-TRAIN
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, -1);
    send(5'b10110, 1'b1);
    repeat (3) begin
      cyc(1'b0, 1'b0, 1'b0, 5'b11111, 1'b1, -1);
      chk("gap_gc_op", gc_op, 1'b1);
      chk("gap_gc_in_hv", gc_in_hv, '0);
      chk("gap_out_valid", out_valid, 1'b0);
    end
    chk("gap_train_count", train_count, 1);
    send(5'b01001, 1'b0);
    send(5'b11100, 1'b1);
    repeat (6) send(DIM'($urandom), 1'b0);

    // Randomized traffic including stray start/stop pulses
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 3) != 0), DIM'($urandom), 1'($urandom_range(0, 1)), -1);
    end

    // Asynchronous reset mid-inference aborts without done
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, -1);
    for (int k = 0; k < 12 && m_mode != M_INFER; k++) send(DIM'($urandom), 1'($urandom_range(0, 1)));
    cyc(1'b0, 1'b0, 1'b1, 5'b10011, 1'b0, -1);
    #2 nrst = 1'b0;
    #1;
    chk_reset_values("abort");
    model_reset();
    in_valid = 1'b0; start = 1'b0; stop = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (3) cyc(1'b0, 1'b1, 1'b1, 5'b00011, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
